// File: rtl/csa_resolve_pkg.sv
// csa_resolve_pkg
// Shared helpers for the carry-save resolve pipeline:
//   seg_w          - carry-chain segment width for a WIDTH/NSEG split
//   csa_params_ok  - elaboration-time legality check of WIDTH/NSEG
//   csa_stage_ctl_t- width-independent part of a pipeline stage record
//                    (valid bit and registered segment carry-out)
package csa_resolve_pkg;

   function automatic int unsigned seg_w(input int unsigned width,
                                         input int unsigned nseg);
      return (nseg == 0) ? 0 : width / nseg;
   endfunction

   function automatic bit csa_params_ok(input int unsigned width,
                                        input int unsigned nseg);
      return (nseg != 0) && (width >= 2) && ((width % nseg) == 0);
   endfunction

   typedef struct packed {
      logic valid;
      logic cout;
   } csa_stage_ctl_t;

endpackage

// File: rtl/csa_seg_add.sv
// csa_seg_add
// Combinational SW-bit adder for one carry-chain segment.
//   a, b  in  SW  operands
//   cin   in  1   carry-in from the previous segment
//   s     out SW  segment sum
//   cout  out 1   segment carry-out
module csa_seg_add #(
   parameter int unsigned SW = 4
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] s,
   output logic          cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
   end

endmodule

// File: rtl/csa_resolve_pipe.sv
// csa_resolve_pipe
// Resolves a carry-save (sum, carry) pair into binary
// (in_sum + (in_carry << 1)) mod 2^WIDTH with the carry chain split into
// NSEG registered segments (latency NSEG, throughput 1/cycle).
//   clk, rst_n           clock (rising) / synchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready = !out_valid || out_ready
//   in_sum, in_carry     CSA vectors (carry has weight 2, MSB discarded)
//   out_valid/out_ready  output handshake
//   out_data             resolved value of the last stage
//   busy                 any stage holds a valid entry
module csa_resolve_pipe
   import csa_resolve_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NSEG  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int unsigned SW = seg_w(WIDTH, NSEG);

   generate
      if (!csa_params_ok(WIDTH, NSEG)) begin : g_bad_params
         $fatal(1, "csa_resolve_pipe: WIDTH must be a multiple of NSEG");
      end
   endgenerate

   // res: segments already resolved; ps/pc: raw operands still pending
   typedef struct packed {
      csa_stage_ctl_t   ctl;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] ps;
      logic [WIDTH-1:0] pc;
   } stage_t;

   stage_t           st_q [NSEG];
   stage_t           st_d [NSEG];

   logic [SW-1:0]    a_w    [NSEG];
   logic [SW-1:0]    b_w    [NSEG];
   logic [SW-1:0]    s_w    [NSEG];
   logic             cin_w  [NSEG];
   logic             cout_w [NSEG];

   logic [WIDTH-1:0] c2;
   logic             adv;

   always_comb begin
      c2 = in_carry << 1;
   end

   // Segment 0 works on the live inputs; segment k on stage k-1's pending
   // operands plus stage k-1's registered carry-out.
   always_comb begin
      a_w[0]   = in_sum[SW-1:0];
      b_w[0]   = c2[SW-1:0];
      cin_w[0] = 1'b0;
      for (int unsigned k = 1; k < NSEG; k++) begin
         a_w[k]   = st_q[k-1].ps[k*SW +: SW];
         b_w[k]   = st_q[k-1].pc[k*SW +: SW];
         cin_w[k] = st_q[k-1].ctl.cout;
      end
   end

   generate
      for (genvar g = 0; g < NSEG; g++) begin : g_seg
         csa_seg_add #(.SW(SW)) u_add (
            .a    (a_w[g]),
            .b    (b_w[g]),
            .cin  (cin_w[g]),
            .s    (s_w[g]),
            .cout (cout_w[g])
         );
      end
   endgenerate

   always_comb begin
      st_d[0]              = '0;
      st_d[0].ctl.valid    = in_valid;
      st_d[0].ctl.cout     = cout_w[0];
      st_d[0].res[SW-1:0]  = s_w[0];
      st_d[0].ps           = in_sum;
      st_d[0].pc           = c2;
      for (int unsigned k = 1; k < NSEG; k++) begin
         st_d[k]                  = st_q[k-1];
         st_d[k].res[k*SW +: SW]  = s_w[k];
         st_d[k].ctl.cout         = cout_w[k];
      end
   end

   always_comb begin
      adv = !st_q[NSEG-1].ctl.valid || out_ready;
   end

   // Data fields load only with a valid entry, so bubbles never disturb
   // out_data and undriven upstream data cannot reach the output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NSEG; k++) begin
            st_q[k] <= '0;
         end
      end else if (adv) begin
         for (int unsigned k = 0; k < NSEG; k++) begin
            st_q[k].ctl.valid <= st_d[k].ctl.valid;
            if (st_d[k].ctl.valid) begin
               st_q[k] <= st_d[k];
            end
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned k = 0; k < NSEG; k++) begin
         busy = busy | st_q[k].ctl.valid;
      end
   end

   assign in_ready  = adv;
   assign out_valid = st_q[NSEG-1].ctl.valid;
   assign out_data  = st_q[NSEG-1].res;

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// tb_csa_resolve_pipe
// Self-checking bench for csa_resolve_pipe (WIDTH=16, NSEG=4). A negedge
// monitor keeps a queue of expected results computed as
// (sum + 2*carry) mod 2^16 at every input handshake and compares them, in
// order, against every output handshake.
module tb_csa_resolve_pipe;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NSEG  = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   csa_resolve_pipe #(.WIDTH(WIDTH), .NSEG(NSEG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;
   int unsigned n_in  = 0;
   int unsigned n_out = 0;
   bit          lat_chk = 1'b0;
   bit          bp_done = 1'b0;

   logic [WIDTH-1:0] exp_q [$];
   int unsigned      acc_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] resolve(input int unsigned s,
                                                input int unsigned c);
      int unsigned t;
      t = (s + 2 * c) % (1 << WIDTH);
      return WIDTH'(t);
   endfunction

   always @(negedge clk) begin
      logic [WIDTH-1:0] e;
      int unsigned      a;
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
      end else begin
         check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
         check("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("out_data", {16'd0, out_data}, {16'd0, e});
               if (lat_chk) check("latency", cyc - a, NSEG);
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(resolve(in_sum, in_carry));
            acc_q.push_back(cyc);
            n_in++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the handshake edge
   // with in_valid still asserted.
   task automatic push(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (NSEG + 4) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      logic [WIDTH-1:0] s5;
      logic [WIDTH-1:0] c5;
      logic [WIDTH-1:0] yprev;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] c;
      logic [WIDTH-1:0] dsum [4];
      logic [WIDTH-1:0] dcar [4];
      int unsigned      xs   [3];
      int unsigned      in0;
      int unsigned      out0;

      dsum = '{16'h00FF, 16'h0FFF, 16'hFFFF, 16'h1234};
      dcar = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
      xs   = '{5, 3, 10};

      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // single pair, then the remaining carry-ripple / wrap cases
      lat_chk = 1'b1;
      push(dsum[0], dcar[0]);
      drain();
      for (int i = 1; i < 4; i++) push(dsum[i], dcar[i]);
      drain();

      // IIR y[n] = x[n] - y[n-1], handed over in random CSA form
      yprev = '0;
      for (int i = 0; i < 3; i++) begin
         y = WIDTH'(xs[i] - yprev);
         c = WIDTH'($urandom);
         push(WIDTH'(y - 2 * c), c);
         yprev = y;
      end
      drain();

      // streaming, back to back
      in0  = n_in;
      out0 = n_out;
      for (int i = 0; i < 100; i++) push(WIDTH'($urandom), WIDTH'($urandom));
      drain();
      check("stream_count", n_out - out0, 32'd100);

      // backpressure: fill, stall 5 cycles, release
      lat_chk   = 1'b0;
      in0       = n_in;
      out0      = n_out;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(WIDTH'($urandom), WIDTH'($urandom));
      s5       = WIDTH'($urandom);
      c5       = WIDTH'($urandom);
      in_valid = 1'b1;
      in_sum   = s5;
      in_carry = c5;
      @(negedge clk);
      check("bp_full_valid", {31'd0, out_valid}, 32'd1);
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_data", {16'd0, out_data}, {16'd0, held});
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      push(s5, c5);
      for (int i = 0; i < 3; i++) push(WIDTH'($urandom), WIDTH'($urandom));
      drain();
      check("bp_count", n_out - out0, n_in - in0);

      // random backpressure
      in0     = n_in;
      out0    = n_out;
      bp_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) push(WIDTH'($urandom), WIDTH'($urandom));
            in_valid = 1'b0;
            bp_done  = 1'b1;
         end
         begin
            while (!bp_done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();
      check("rbp_count", n_out - out0, n_in - in0);

      // reset with three entries in flight; input during reset is dropped
      lat_chk = 1'b1;
      for (int i = 0; i < 3; i++) push(WIDTH'($urandom), WIDTH'($urandom));
      rst_n    = 1'b0;
      in_sum   = 16'hAAAA;
      in_carry = 16'h5555;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_out_data", {16'd0, out_data}, 32'd0);
      @(posedge clk);
      #1;
      out0 = n_out;
      push(16'h0102, 16'h0304);
      drain();
      check("mrst_count", n_out - out0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/csa_resolve_pipe.md
Name: csa_resolve_pipe

Overview:
- Downstream stage of the carry-save IIR subtractor.
- Consumes the redundant (sum, carry) pair and produces the binary value sum + (carry << 1), computed modulo 2^WIDTH.
- The carry chain is split into NSEG pipelined segments so that the long resolve add is removed from the IIR feedback timing path.
- Uses a valid/ready handshake with full-pipeline backpressure toward the output consumer (decimator/output register).

Parameters:
- WIDTH, 16, datapath width in bits. Must equal the IIR width.
- NSEG, 4, number of carry-chain segments, which is also the pipeline depth. WIDTH % NSEG == 0 is required; violation is an elaboration-time fatal error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input pair valid.
- in_ready  out  1  stage can accept the input pair this cycle.
- in_sum  in  WIDTH  CSA sum vector.
- in_carry  in  WIDTH  CSA carry vector (weight 2; the bit at WIDTH-1 shifts out and is discarded).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  resolved binary value, (in_sum + (in_carry << 1)) mod 2^WIDTH.
- busy  out  1  at least one pipeline stage holds a valid entry.

Behaviour:
- Transfer occurs on a clock edge when valid && ready on the same side.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational; there is no skid buffer.
  - When adv = 0, all stage registers hold their contents.
- Segment width is SW = WIDTH/NSEG. Segment k covers bits [k*SW +: SW].
- Input capture (stage 0): form the shifted carry c2 = in_carry << 1, truncated to WIDTH.
  - Stage 0 adds segment 0 of in_sum and c2, with carry-in 0.
  - It registers the SW-bit result and the segment carry-out.
  - It registers the raw sum and c2 slices for segments 1..NSEG-1.
- Stage k (1..NSEG-1):
  - Adds its delayed segment-k operands plus the registered carry-out from stage k-1.
  - Registers that result and its carry-out.
  - Passes forward the already-resolved lower segments and the still-pending upper operands.
- Each stage has one valid bit that moves forward on adv. Bubbles propagate; there is no compaction.
- Carry-out of the top segment is discarded (modular arithmetic, matching the binary IIR path).
- Latency is NSEG cycles from input acceptance to out_valid, with no stall.
  - Throughput is 1 pair/cycle while out_ready = 1.
  - NSEG = 1 degenerates to a single registered full add with latency 1.
- out_data is the fully resolved register of the last stage.
  - It is stable while out_valid && !out_ready.
  - It is don't-care when out_valid = 0, but the implementation must drive the last registered value and never X after reset.
- busy = OR of all stage valid bits.
- Reset (rst_n = 0 at a clock edge):
  - All valid bits clear and all data registers clear to 0.
  - Therefore out_valid = 0, out_data = 0, busy = 0, and in_ready = 1 from the first cycle after reset.
  - Asserting reset mid-operation flushes every in-flight entry with no partial output.
  - Any input presented during the reset cycle is dropped.
- Simultaneous events:
  - in_valid together with out_ready while the pipe is full: output pops and input enters in the same cycle.
  - in_valid while adv = 0: the input is not accepted. The upstream must hold it (AXI-style; in_valid must not drop before acceptance).
- Wrap-around: overflow wraps silently; there is no flag.

Decomposition:
- Package csa_resolve_pkg provides:
  - the function seg_w(WIDTH, NSEG);
  - a localparam check helper;
  - the typedef of the per-stage record (valid, resolved bits, pending sum, pending carry, cout).
- Sub-module csa_seg_add:
  - Parameter SW.
  - Combinational SW-bit adder: inputs a, b, cin; outputs s, cout.
  - Instantiated NSEG times via a generate loop. Registers stay in the parent.

Test Plan (WIDTH=16, NSEG=4):
- Single pair: in_sum=0x00FF, in_carry=0x0001 -> out_data=0x0101 with out_valid exactly 4 cycles after acceptance.
- Cross-segment carry ripple: sum=0x0FFF, carry=0x0000_0000_0000_0001 (0x0001) -> 0x1001. Also sum=0xFFFF, carry=0x0001 -> 0x0001 (wrap); carry=0x8000, sum=0x1234 -> 0x1234 (MSB dropped).
- Streaming with out_ready=1: 100 random pairs, one per cycle -> 100 outputs in order, each matching the golden model (s + (c<<1)) & 0xFFFF, with no gaps.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable. Then release -> no loss and no duplication; count out == count in.
- Chained with the IIR subtractor, sample sequence 5, 3, 10 from reset -> outputs 5, 0xFFFE (-2), 12, equal to the registered binary IIR output delayed by NSEG.
- Reset mid-flight: 3 entries in flight, rst_n=0 for 1 cycle -> busy=0, out_valid=0, out_data=0 on the next cycle. The next accepted pair is the first one output.
